controle_tentativas: RTL and testbench



---
 rtl/controle_tentativas_pkg.sv | 15 +
 rtl/somador4bits.sv | 21 ++
 rtl/controle_tentativas.sv | 123 ++++++++++++
 tb/tb_controle_tentativas.sv | 123 ++++++++++++
 4 files changed

// File: rtl/controle_tentativas_pkg.sv
// Shared definitions for the safe's attempt/lockout controller:
// state encoding, datapath width and default timing/limit values.
package controle_tentativas_pkg;
   localparam int W = 4;

   typedef enum logic [1:0] {
      LIVRE     = 2'd0,
      ABERTO    = 2'd1,
      BLOQUEADO = 2'd2
   } estado_t;

   localparam int MAX_TENTATIVAS_DEF = 3;
   localparam int TEMPO_BLOQUEIO_DEF = 10;
   localparam int TEMPO_ABERTO_DEF   = 5;
endpackage

// File: rtl/somador4bits.sv
// 4-bit ripple-carry adder used as the controller's only arithmetic stage.
module somador4bits
   import controle_tentativas_pkg::*;
(
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         cin_i,
   output logic [W-1:0] s_o,
   output logic         cout_o
);
   logic [W:0] c;

   assign c[0] = cin_i;

   for (genvar i = 0; i < W; i++) begin : g_fa
      assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
   end

   assign cout_o = c[W];
endmodule

// File: rtl/controle_tentativas.sv
// Attempt counter and lockout/open timer FSM for the digital safe.
// Counter increment and timer decrement both go through somador4bits.
module controle_tentativas
   import controle_tentativas_pkg::*;
#(
   parameter int MAX_TENTATIVAS = MAX_TENTATIVAS_DEF,
   parameter int TEMPO_BLOQUEIO = TEMPO_BLOQUEIO_DEF,
   parameter int TEMPO_ABERTO   = TEMPO_ABERTO_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         verifica,
   input  logic         senha_ok,
   input  logic         tick,
   input  logic         fechar,
   output logic [W-1:0] tentativas,
   output logic [W-1:0] tempo_restante,
   output logic         aberto,
   output logic         bloqueado,
   output logic         erro
);
   localparam logic [W-1:0] MAX_T = W'(MAX_TENTATIVAS);
   localparam logic [W-1:0] T_BLQ = W'(TEMPO_BLOQUEIO);
   localparam logic [W-1:0] T_ABR = W'(TEMPO_ABERTO);
   localparam logic [W-1:0] UM    = W'(1);

   estado_t      estado_q, estado_d;
   logic [W-1:0] tent_q, tent_d;
   logic [W-1:0] tempo_q, tempo_d;
   logic         erro_q, erro_d;
   logic [W-1:0] inc_s, dec_s;

   somador4bits u_inc (
      .a_i    (tent_q),
      .b_i    ('0),
      .cin_i  (1'b1),
      .s_o    (inc_s),
      .cout_o ()
   );

   // Adding all-ones without carry-in is a modulo-16 decrement.
   somador4bits u_dec (
      .a_i    (tempo_q),
      .b_i    ('1),
      .cin_i  (1'b0),
      .s_o    (dec_s),
      .cout_o ()
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_q <= LIVRE;
         tent_q   <= '0;
         tempo_q  <= '0;
         erro_q   <= 1'b0;
      end else begin
         estado_q <= estado_d;
         tent_q   <= tent_d;
         tempo_q  <= tempo_d;
         erro_q   <= erro_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      tent_d   = tent_q;
      tempo_d  = tempo_q;
      erro_d   = 1'b0;
      case (estado_q)
         LIVRE: begin
            if (verifica) begin
               if (senha_ok) begin
                  estado_d = ABERTO;
                  tent_d   = '0;
                  tempo_d  = T_ABR;
               end else begin
                  erro_d = 1'b1;
                  if (inc_s == MAX_T) begin
                     estado_d = BLOQUEADO;
                     tent_d   = MAX_T;
                     tempo_d  = T_BLQ;
                  end else begin
                     tent_d = inc_s;
                  end
               end
            end
         end
         ABERTO: begin
            if (fechar || (tick && tempo_q == UM)) begin
               estado_d = LIVRE;
               tempo_d  = '0;
            end else if (tick) begin
               tempo_d = dec_s;
            end
         end
         BLOQUEADO: begin
            if (tick) begin
               if (tempo_q == UM) begin
                  estado_d = LIVRE;
                  tent_d   = '0;
                  tempo_d  = '0;
               end else begin
                  tempo_d = dec_s;
               end
            end
         end
         default: begin
            estado_d = LIVRE;
            tent_d   = '0;
            tempo_d  = '0;
         end
      endcase
   end

   // Status flags decode the registered state, so they stay glitch-free.
   always_comb begin
      tentativas     = tent_q;
      tempo_restante = tempo_q;
      aberto         = (estado_q == ABERTO);
      bloqueado      = (estado_q == BLOQUEADO);
      erro           = erro_q;
   end
endmodule

// File: tb/tb_controle_tentativas.sv
// Directed bench for controle_tentativas: default instance plus a
// MAX_TENTATIVAS=1 / TEMPO_BLOQUEIO=1 instance sharing the same inputs.
module tb_controle_tentativas;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       verifica = 1'b0, senha_ok = 1'b0, tick = 1'b0, fechar = 1'b0;
   logic [3:0] tent0, tempo0, tent1, tempo1;
   logic       ab0, bl0, er0, ab1, bl1, er1;

   int checks = 0;
   int errors = 0;

   string      tag_q[$];
   logic [11:0] exp_q[$];

   always #5 clk = ~clk;

   controle_tentativas dut0 (
      .clk(clk), .rst(rst), .verifica(verifica), .senha_ok(senha_ok),
      .tick(tick), .fechar(fechar), .tentativas(tent0),
      .tempo_restante(tempo0), .aberto(ab0), .bloqueado(bl0), .erro(er0)
   );

   controle_tentativas #(.MAX_TENTATIVAS(1), .TEMPO_BLOQUEIO(1)) dut1 (
      .clk(clk), .rst(rst), .verifica(verifica), .senha_ok(senha_ok),
      .tick(tick), .fechar(fechar), .tentativas(tent1),
      .tempo_restante(tempo1), .aberto(ab1), .bloqueado(bl1), .erro(er1)
   );

   task automatic push(input string tag, input logic sel, input logic [3:0] et,
                       input logic [3:0] ep, input logic ea, input logic eb,
                       input logic ee);
      tag_q.push_back(tag);
      exp_q.push_back({sel, et, ep, ea, eb, ee});
   endtask

   task automatic check_pop();
      string       tag;
      logic [11:0] e;
      logic [10:0] obs;
      tag = tag_q.pop_front();
      e   = exp_q.pop_front();
      obs = e[11] ? {tent1, tempo1, ab1, bl1, er1} : {tent0, tempo0, ab0, bl0, er0};
      checks++;
      assert (obs === e[10:0]) else begin
         errors++;
         $error("FAIL %s observed tent=%0d tempo=%0d ab=%b bl=%b erro=%b expected tent=%0d tempo=%0d ab=%b bl=%b erro=%b",
                tag, obs[10:7], obs[6:3], obs[2], obs[1], obs[0],
                e[10:7], e[6:3], e[2], e[1], e[0]);
      end
   endtask

   // Drive one cycle of inputs, record the expectation, sample after the edge.
   task automatic cyc(input string tag, input logic v, input logic ok,
                      input logic t, input logic f, input logic sel,
                      input logic [3:0] et, input logic [3:0] ep,
                      input logic ea, input logic eb, input logic ee);
      verifica = v; senha_ok = ok; tick = t; fechar = f;
      push(tag, sel, et, ep, ea, eb, ee);
      @(posedge clk); #1;
      check_pop();
      verifica = 0; senha_ok = 0; tick = 0; fechar = 0;
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      push("reset0", 0, 0, 0, 0, 0, 0); check_pop();
      push("reset1", 1, 0, 0, 0, 0, 0); check_pop();
      rst = 1'b0;

      // idle inputs ignored in LIVRE
      cyc("livre_tick_fechar", 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);

      // T1: correct password, then open timer runs out
      cyc("t1_open", 1, 1, 0, 0, 0, 0, 5, 1, 0, 0);
      for (int i = 1; i <= 5; i++)
         cyc($sformatf("t1_tick%0d", i), 0, 0, 1, 0, 0, 0, 4'(5 - i), (i < 5), 0, 0);

      // T2: three wrong attempts lock the safe
      cyc("t2_wrong1", 1, 0, 0, 0, 0, 1, 0, 0, 0, 1);
      cyc("t2_erro_pulse", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      cyc("t2_wrong2", 1, 0, 0, 0, 0, 2, 0, 0, 0, 1);
      cyc("t2_wrong3", 1, 0, 0, 0, 0, 3, 10, 0, 1, 1);
      cyc("t2_ok_ignored", 1, 1, 0, 0, 0, 3, 10, 0, 1, 0);
      cyc("t2_fechar_ignored", 0, 0, 0, 1, 0, 3, 10, 0, 1, 0);

      // T3: lockout countdown
      for (int i = 1; i <= 10; i++)
         cyc($sformatf("t3_tick%0d", i), 0, 0, 1, 0, 0,
             (i < 10) ? 4'd3 : 4'd0, 4'(10 - i), 0, (i < 10), 0);

      // T4: two wrong then correct; fechar wins over tick
      cyc("t4_wrong1", 1, 0, 0, 0, 0, 1, 0, 0, 0, 1);
      cyc("t4_wrong2", 1, 0, 0, 0, 0, 2, 0, 0, 0, 1);
      cyc("t4_open", 1, 1, 0, 0, 0, 0, 5, 1, 0, 0);
      cyc("t4_verifica_ignored", 1, 0, 0, 0, 0, 0, 5, 1, 0, 0);
      cyc("t4_tick", 0, 0, 1, 0, 0, 0, 4, 1, 0, 0);
      cyc("t4_fechar_tick", 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);

      // T5: asynchronous reset mid-lockout
      cyc("t5_wrong1", 1, 0, 0, 0, 0, 1, 0, 0, 0, 1);
      cyc("t5_wrong2", 1, 0, 0, 0, 0, 2, 0, 0, 0, 1);
      cyc("t5_wrong3", 1, 0, 0, 0, 0, 3, 10, 0, 1, 1);
      for (int i = 1; i <= 4; i++)
         cyc($sformatf("t5_tick%0d", i), 0, 0, 1, 0, 0, 3, 4'(10 - i), 0, 1, 0);
      #3 rst = 1'b1;
      #1;
      push("t5_async_rst", 0, 0, 0, 0, 0, 0); check_pop();
      @(posedge clk); #1;
      rst = 1'b0;

      // T6: MAX_TENTATIVAS=1, TEMPO_BLOQUEIO=1 instance
      push("t6_reset", 1, 0, 0, 0, 0, 0); check_pop();
      cyc("t6_wrong_locks", 1, 0, 0, 0, 1, 1, 1, 0, 1, 1);
      cyc("t6_tick_exits", 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
      cyc("t6_idle", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
